// File: rtl/led_matrix_scanner.sv
// Row-multiplexed LED matrix driver with a double-buffered frame store.
// Rows are lit one at a time for DWELL cycles, separated by BLANK all-off cycles.
module led_matrix_scanner #(
   parameter int ROWS            = 5,
   parameter int COLS            = 7,
   parameter int DWELL           = 1000,
   parameter int BLANK           = 16,
   parameter bit ROW_ACTIVE_HIGH = 1'b1,
   parameter bit COL_ACTIVE_HIGH = 1'b1,
   localparam int RW = ($clog2(ROWS) > 1) ? $clog2(ROWS) : 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            enable,
   input  logic            wr_en,
   input  logic [RW-1:0]   wr_row,
   input  logic [COLS-1:0] wr_data,
   input  logic            swap,
   output logic [ROWS-1:0] row,
   output logic [COLS-1:0] col,
   output logic            frame_start,
   output logic            swap_done
);

   localparam int MAXC = (DWELL > BLANK) ? DWELL : BLANK;
   localparam int CW   = $clog2(MAXC + 1);

   typedef enum logic [1:0] {ST_IDLE, ST_BLANK, ST_ON} state_t;

   state_t          state, next_state;
   logic [RW-1:0]   r, next_r;
   logic [CW-1:0]   cnt, next_cnt;
   logic            bank, next_bank;
   logic            swap_pend;
   logic            boundary, do_swap, wr_ok, lit;
   logic [ROWS-1:0] row_d;
   logic [COLS-1:0] col_d, front_row;
   logic            frame_d;
   logic [COLS-1:0] mem [2][ROWS];

   assign wr_ok = wr_en && (int'(wr_row) < ROWS);

   always_comb begin
      next_state = state;
      next_r     = r;
      next_cnt   = cnt;
      boundary   = 1'b0;
      if (!enable) begin
         next_state = ST_IDLE;
         next_r     = '0;
         next_cnt   = '0;
      end else begin
         case (state)
            ST_IDLE: begin
               next_r   = '0;
               next_cnt = '0;
               if (BLANK > 0) next_state = ST_BLANK;
               else           next_state = ST_ON;
            end
            ST_BLANK: begin
               if (cnt == CW'(BLANK - 1)) begin
                  next_state = ST_ON;
                  next_cnt   = '0;
               end else begin
                  next_cnt = cnt + 1'b1;
               end
            end
            ST_ON: begin
               if (cnt == CW'(DWELL - 1)) begin
                  next_cnt = '0;
                  if (BLANK > 0) next_state = ST_BLANK;
                  else           next_state = ST_ON;
                  if (r == RW'(ROWS - 1)) begin
                     next_r   = '0;
                     boundary = 1'b1;
                  end else begin
                     next_r = r + 1'b1;
                  end
               end else begin
                  next_cnt = cnt + 1'b1;
               end
            end
            default: begin
               next_state = ST_IDLE;
               next_r     = '0;
               next_cnt   = '0;
            end
         endcase
      end
   end

   // A write landing on the bank that becomes FRONT at this very edge must be
   // forwarded, otherwise the first lit cycle would show the stale pattern.
   always_comb begin
      do_swap   = boundary && (swap_pend || swap);
      next_bank = bank ^ do_swap;
      front_row = mem[next_bank][next_r];
      if (wr_ok && (wr_row == next_r) && (next_bank != bank))
         front_row = wr_data;
      lit     = (next_state == ST_ON);
      row_d   = lit ? (ROWS'(1) << next_r) : '0;
      col_d   = lit ? front_row : '0;
      frame_d = lit && (next_r == '0) && !((state == ST_ON) && (r == '0));
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         r           <= '0;
         cnt         <= '0;
         bank        <= 1'b0;
         swap_pend   <= 1'b0;
         row         <= {ROWS{~ROW_ACTIVE_HIGH}};
         col         <= {COLS{~COL_ACTIVE_HIGH}};
         frame_start <= 1'b0;
         swap_done   <= 1'b0;
      end else begin
         state       <= next_state;
         r           <= next_r;
         cnt         <= next_cnt;
         bank        <= next_bank;
         swap_pend   <= do_swap ? 1'b0 : (swap_pend | swap);
         row         <= row_d ^ {ROWS{~ROW_ACTIVE_HIGH}};
         col         <= col_d ^ {COLS{~COL_ACTIVE_HIGH}};
         frame_start <= frame_d;
         swap_done   <= do_swap;
      end
   end

   // Writes always target the bank not currently displayed.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int b = 0; b < 2; b++)
            for (int i = 0; i < ROWS; i++)
               mem[b][i] <= '0;
      end else if (wr_ok) begin
         mem[~bank][wr_row] <= wr_data;
      end
   end

endmodule

// File: tb/tb_led_matrix_scanner.sv
// Directed bench for led_matrix_scanner: one active-high 5x7 instance with
// blanking, one active-low instance with no blanking.
module tb_led_matrix_scanner;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       enable = 1'b0, wr_en = 1'b0, swap = 1'b0;
   logic [2:0] wr_row = '0;
   logic [6:0] wr_data = '0;
   logic [4:0] row;
   logic [6:0] col;
   logic       frame_start, swap_done;

   logic       b_enable = 1'b0, b_wr_en = 1'b0, b_swap = 1'b0;
   logic [2:0] b_wr_row = '0;
   logic [6:0] b_wr_data = '0;
   logic [4:0] b_row;
   logic [6:0] b_col;
   logic       b_frame_start, b_swap_done;

   int vectors = 0;
   int miscompares = 0;
   int k = 0;

   logic [4:0][6:0] zero_f = '0;
   logic [4:0][6:0] pats   = {7'h10, 7'h08, 7'h04, 7'h02, 7'h01};
   logic [4:0][6:0] f7f    = {7'h00, 7'h00, 7'h00, 7'h00, 7'h7F};
   logic [4:0][6:0] bpats  = {7'h11, 7'h00, 7'h7F, 7'h2A, 7'h55};
   logic [4:0][6:0] b3c    = {7'h00, 7'h00, 7'h00, 7'h00, 7'h3C};

   led_matrix_scanner #(.ROWS(5), .COLS(7), .DWELL(4), .BLANK(2),
                        .ROW_ACTIVE_HIGH(1'b1), .COL_ACTIVE_HIGH(1'b1)) dut_a (
      .clk(clk), .rst_n(rst_n), .enable(enable), .wr_en(wr_en),
      .wr_row(wr_row), .wr_data(wr_data), .swap(swap),
      .row(row), .col(col), .frame_start(frame_start), .swap_done(swap_done));

   led_matrix_scanner #(.ROWS(5), .COLS(7), .DWELL(4), .BLANK(0),
                        .ROW_ACTIVE_HIGH(1'b0), .COL_ACTIVE_HIGH(1'b0)) dut_b (
      .clk(clk), .rst_n(rst_n), .enable(b_enable), .wr_en(b_wr_en),
      .wr_row(b_wr_row), .wr_data(b_wr_data), .swap(b_swap),
      .row(b_row), .col(b_col), .frame_start(b_frame_start), .swap_done(b_swap_done));

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
      k++;
   endtask

   // Expected row/col for dut_a at offset p from a frame start (period 30, row period 6).
   function automatic logic [4:0] exp_row(int p);
      int q = p % 30;
      if ((q % 6) < 2) return 5'd0;
      return 5'd1 << (q / 6);
   endfunction

   function automatic logic [6:0] exp_col(int p, logic [4:0][6:0] f);
      int q = p % 30;
      if ((q % 6) < 2) return 7'd0;
      return f[q / 6];
   endfunction

   task automatic write_a(input logic [2:0] r, input logic [6:0] d);
      wr_en = 1'b1; wr_row = r; wr_data = d;
      tick();
      wr_en = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; enable = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         vectors++;
         if ({row, col, frame_start, swap_done} !== 14'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_hold got row=%b col=%h fs=%b sd=%b want all 0", row, col, frame_start, swap_done);
         end
      end
      rst_n = 1'b1;
      for (int i = 0; i < 50; i++) begin
         tick();
         vectors++;
         if ({row, col, frame_start, swap_done} !== 14'd0) begin
            miscompares++;
            $display("[TB] FAIL idle cyc=%0d got row=%b col=%h fs=%b sd=%b want all 0", i, row, col, frame_start, swap_done);
         end
      end
   endtask

   task automatic test_scan_order();
      logic [13:0] want;
      for (int i = 0; i < 5; i++) write_a(3'(i), pats[i]);
      swap = 1'b1;
      tick();
      swap = 1'b0; enable = 1'b1;
      tick();
      k = 0;
      while (k < 90) begin
         want = {exp_row(k), exp_col(k, (k < 30) ? zero_f : pats), (k % 30) == 2, k == 30};
         vectors++;
         if ({row, col, frame_start, swap_done} !== want) begin
            miscompares++;
            $display("[TB] FAIL scan k=%0d got %b_%h_%b_%b want %b", k, row, col, frame_start, swap_done, want);
         end
         tick();
      end
   endtask

   task automatic test_swap_timing();
      logic [13:0] want;
      int start;
      while ((k % 30) != 14) tick();
      start = k;
      while (k <= 152) begin
         want = {exp_row(k), exp_col(k, (k < 120) ? pats : f7f), (k % 30) == 2, k == 120};
         vectors++;
         if ({row, col, frame_start, swap_done} !== want) begin
            miscompares++;
            $display("[TB] FAIL swap k=%0d got %b_%h_%b_%b want %b", k, row, col, frame_start, swap_done, want);
         end
         wr_en   = (k == start);
         wr_row  = 3'd0;
         wr_data = 7'h7F;
         swap    = (k == start + 1) || (k == start + 3) || (k == start + 5);
         tick();
      end
      wr_en = 1'b0; swap = 1'b0;
   endtask

   task automatic test_out_of_range();
      logic [13:0] want;
      int start = k;
      while (k <= 215) begin
         want = {exp_row(k), exp_col(k, (k < 180) ? f7f : pats), (k % 30) == 2, k == 180};
         vectors++;
         if ({row, col, frame_start, swap_done} !== want) begin
            miscompares++;
            $display("[TB] FAIL oob k=%0d got %b_%h_%b_%b want %b", k, row, col, frame_start, swap_done, want);
         end
         wr_en   = (k == start);
         wr_row  = 3'd5;
         wr_data = 7'h7F;
         swap    = (k == start + 1);
         tick();
      end
      wr_en = 1'b0; swap = 1'b0;
   endtask

   task automatic test_disable_reset();
      logic [13:0] want;
      while ((k % 30) != 21) tick();
      vectors++;
      if ({row, col} !== {5'b01000, 7'h08}) begin
         miscompares++;
         $display("[TB] FAIL pre_disable got row=%b col=%h want 01000 08", row, col);
      end
      enable = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         vectors++;
         if ({row, col, frame_start, swap_done} !== 14'd0) begin
            miscompares++;
            $display("[TB] FAIL disabled cyc=%0d got %b_%h_%b_%b want all 0", i, row, col, frame_start, swap_done);
         end
      end
      enable = 1'b1;
      tick();
      k = 0;
      while (k <= 3) begin
         want = {exp_row(k), exp_col(k, pats), k == 2, 1'b0};
         vectors++;
         if ({row, col, frame_start, swap_done} !== want) begin
            miscompares++;
            $display("[TB] FAIL reenable k=%0d got %b_%h_%b_%b want %b", k, row, col, frame_start, swap_done, want);
         end
         if (k < 3) tick();
         else break;
      end
      rst_n = 1'b0; swap = 1'b1;
      tick();
      swap = 1'b0;
      for (int i = 0; i < 2; i++) begin
         vectors++;
         if ({row, col, frame_start, swap_done} !== 14'd0) begin
            miscompares++;
            $display("[TB] FAIL mid_reset cyc=%0d got %b_%h_%b_%b want all 0", i, row, col, frame_start, swap_done);
         end
         tick();
      end
      rst_n = 1'b1; enable = 1'b0;
      tick();
      enable = 1'b1;
      tick();
      k = 0;
      while (k <= 35) begin
         want = {exp_row(k), 7'h00, (k % 30) == 2, 1'b0};
         vectors++;
         if ({row, col, frame_start, swap_done} !== want) begin
            miscompares++;
            $display("[TB] FAIL cleared k=%0d got %b_%h_%b_%b want %b", k, row, col, frame_start, swap_done, want);
         end
         tick();
      end
      enable = 1'b0;
   endtask

   task automatic test_active_low();
      logic [13:0]     want;
      logic [4:0][6:0] f;
      int              idx;
      vectors++;
      if ({b_row, b_col, b_frame_start, b_swap_done} !== {5'h1F, 7'h7F, 2'b00}) begin
         miscompares++;
         $display("[TB] FAIL b_idle got row=%b col=%h want 11111 7f", b_row, b_col);
      end
      for (int i = 0; i < 5; i++) begin
         b_wr_en = 1'b1; b_wr_row = 3'(i); b_wr_data = bpats[i];
         tick();
      end
      b_wr_en = 1'b0; b_swap = 1'b1;
      tick();
      b_swap = 1'b0; b_enable = 1'b1;
      tick();
      k = 0;
      while (k <= 45) begin
         f   = (k < 20) ? zero_f : ((k < 40) ? bpats : b3c);
         idx = (k % 20) / 4;
         want = {~(5'd1 << idx), ~f[idx], (k % 20) == 0, (k == 20) || (k == 40)};
         vectors++;
         if ({b_row, b_col, b_frame_start, b_swap_done} !== want) begin
            miscompares++;
            $display("[TB] FAIL lowpol k=%0d got %b_%h_%b_%b want %b", k, b_row, b_col, b_frame_start, b_swap_done, want);
         end
         b_wr_en   = (k == 39);
         b_wr_row  = 3'd0;
         b_wr_data = 7'h3C;
         b_swap    = (k == 39);
         tick();
      end
      b_wr_en = 1'b0; b_swap = 1'b0; b_enable = 1'b0;
   endtask

   initial begin
      test_reset();
      test_scan_order();
      test_swap_timing();
      test_out_of_range();
      test_disable_reset();
      test_active_low();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
